// File: rtl/arb_requester_pkg.sv
// arb_requester_pkg: shared definitions for the requester-side arbiter client.
//   - arb_state_e : per-channel FSM state encoding
//   - *Default    : default channel count, beat-count width and wait timeout
package arb_requester_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StWait = 2'd1,
    StOwn  = 2'd2,
    StRel  = 2'd3
  } arb_state_e;

  localparam int unsigned NchDefault  = 3;
  localparam int unsigned LenWDefault = 4;
  localparam int unsigned TmoDefault  = 16;

endpackage

// File: rtl/arb_requester_if.sv
// arb_requester_if: job, request/grant and status signals of the requester block.
//   job_valid/job_len/job_ready : per-channel job offer and acceptance
//   req/gnt                     : request lines to / grant lines from the arbiter
//   beat_valid                  : channel owns the resource and drives a beat
//   done/err_tmo/err_lost       : per-channel completion and error pulses
//   gnt_err                     : grant bus protocol fault pulse
// Modport master is the requester block; slave is the job source / arbiter side.
interface arb_requester_if
  import arb_requester_pkg::*;
#(
  parameter int unsigned NCH   = NchDefault,
  parameter int unsigned LEN_W = LenWDefault
);
  logic [NCH-1:0]       job_valid;
  logic [NCH*LEN_W-1:0] job_len;
  logic [NCH-1:0]       job_ready;
  logic [NCH-1:0]       req;
  logic [NCH-1:0]       gnt;
  logic [NCH-1:0]       beat_valid;
  logic [NCH-1:0]       done;
  logic [NCH-1:0]       err_tmo;
  logic [NCH-1:0]       err_lost;
  logic                 gnt_err;

  modport master (
    input  job_valid, job_len, gnt,
    output job_ready, req, beat_valid, done, err_tmo, err_lost, gnt_err
  );

  modport slave (
    output job_valid, job_len, gnt,
    input  job_ready, req, beat_valid, done, err_tmo, err_lost, gnt_err
  );
endinterface

// File: rtl/arb_requester_chan.sv
// arb_requester_chan: one requester channel.
//   clk, rst   : clock, asynchronous active-low reset
//   job_valid  : job offer; job_len : beat count (0 is run as 1)
//   gnt_ok     : this channel's grant bit, already qualified by bus validity
//   job_ready  : idle and accepting
//   req        : request to the arbiter (WAIT and OWN)
//   beat_valid : owning the resource this cycle with the grant still present
//   done       : pulse in the release cycle after a normal burst
//   err_tmo    : pulse in the cycle after WAIT expired
//   err_lost   : pulse in the release cycle after the grant vanished mid-burst
module arb_requester_chan
  import arb_requester_pkg::*;
#(
  parameter int unsigned LEN_W = LenWDefault,
  parameter int unsigned TMO   = TmoDefault
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             job_valid,
  input  logic [LEN_W-1:0] job_len,
  input  logic             gnt_ok,
  output logic             job_ready,
  output logic             req,
  output logic             beat_valid,
  output logic             done,
  output logic             err_tmo,
  output logic             err_lost
);
  localparam int unsigned     WaitW    = $clog2(TMO + 1);
  localparam logic [WaitW-1:0] WaitLast = WaitW'(TMO - 1);

  arb_state_e       state_q, state_d;
  logic [WaitW-1:0] wait_cnt_q, wait_cnt_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] beat_cnt_q, beat_cnt_d;
  logic             lost_q, lost_d;
  logic             tmo_q, tmo_d;

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    len_d      = len_q;
    beat_cnt_d = beat_cnt_q;
    lost_d     = lost_q;
    tmo_d      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (job_valid) begin
          len_d      = (job_len == '0) ? LEN_W'(1) : job_len;
          wait_cnt_d = '0;
          beat_cnt_d = '0;
          lost_d     = 1'b0;
          state_d    = StWait;
        end
      end
      StWait: begin
        // A grant in the expiry cycle takes priority over the timeout.
        if (gnt_ok) begin
          state_d    = StOwn;
          wait_cnt_d = '0;
          beat_cnt_d = '0;
        end else if (wait_cnt_q == WaitLast) begin
          state_d    = StIdle;
          tmo_d      = 1'b1;
          wait_cnt_d = '0;
        end else if (wait_cnt_q != '1) begin
          wait_cnt_d = wait_cnt_q + WaitW'(1);
        end
      end
      StOwn: begin
        if (!gnt_ok) begin
          lost_d  = 1'b1;
          state_d = StRel;
        end else if (beat_cnt_q == len_q - LEN_W'(1)) begin
          state_d = StRel;
        end else if (beat_cnt_q != '1) begin
          beat_cnt_d = beat_cnt_q + LEN_W'(1);
        end
      end
      StRel: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      wait_cnt_q <= '0;
      len_q      <= '0;
      beat_cnt_q <= '0;
      lost_q     <= 1'b0;
      tmo_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      len_q      <= len_d;
      beat_cnt_q <= beat_cnt_d;
      lost_q     <= lost_d;
      tmo_q      <= tmo_d;
    end
  end

  always_comb begin
    job_ready  = (state_q == StIdle);
    req        = (state_q == StWait) || (state_q == StOwn);
    // Drops in the same cycle the grant disappears so no beat is driven unowned.
    beat_valid = (state_q == StOwn) && gnt_ok;
    done       = (state_q == StRel) && !lost_q;
    err_lost   = (state_q == StRel) && lost_q;
    err_tmo    = tmo_q;
  end

endmodule

// File: rtl/arb_requester.sv
// arb_requester: NCH requester channels in front of a round-robin arbiter.
//   clk, rst : clock, asynchronous active-low reset
//   bus      : arb_requester_if master modport (jobs, req/gnt, beats, status pulses)
// The grant bus is qualified here: a vector that is not one-hot/zero or that grants a
// channel without a registered request is ignored by every channel and flagged on
// gnt_err one cycle later.
module arb_requester
  import arb_requester_pkg::*;
#(
  parameter int unsigned NCH   = NchDefault,
  parameter int unsigned LEN_W = LenWDefault,
  parameter int unsigned TMO   = TmoDefault
) (
  input logic          clk,
  input logic          rst,
  arb_requester_if.master bus
);
  logic [NCH-1:0] req;
  logic [NCH-1:0] job_ready;
  logic [NCH-1:0] beat_valid;
  logic [NCH-1:0] done;
  logic [NCH-1:0] err_tmo;
  logic [NCH-1:0] err_lost;
  logic [NCH-1:0] gnt_ok;
  logic           gnt_valid;
  logic           gnt_err_q;

  assign gnt_valid = $onehot0(bus.gnt) && ((bus.gnt & ~req) == '0);
  assign gnt_ok    = bus.gnt & {NCH{gnt_valid}};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      gnt_err_q <= 1'b0;
    end else begin
      gnt_err_q <= !gnt_valid;
    end
  end

  for (genvar i = 0; i < NCH; i++) begin : g_chan
    arb_requester_chan #(
      .LEN_W (LEN_W),
      .TMO   (TMO)
    ) u_chan (
      .clk        (clk),
      .rst        (rst),
      .job_valid  (bus.job_valid[i]),
      .job_len    (bus.job_len[i*LEN_W +: LEN_W]),
      .gnt_ok     (gnt_ok[i]),
      .job_ready  (job_ready[i]),
      .req        (req[i]),
      .beat_valid (beat_valid[i]),
      .done       (done[i]),
      .err_tmo    (err_tmo[i]),
      .err_lost   (err_lost[i])
    );
  end

  assign bus.req        = req;
  assign bus.job_ready  = job_ready;
  assign bus.beat_valid = beat_valid;
  assign bus.done       = done;
  assign bus.err_tmo    = err_tmo;
  assign bus.err_lost   = err_lost;
  assign bus.gnt_err    = gnt_err_q;

endmodule
